// File: rtl/pit_multi.sv
// Multi-channel programmable interval timer behind a Wishbone slave port.
// Optional macro PIT_CHAIN_EN lets channel n>0 count rollovers of channel n-1.
module pit_multi #(
    parameter int NCH        = 4,
    parameter int COUNT_SIZE = 16,
    parameter int PRE_SIZE   = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [4:0]      wb_adr_i,
    input  logic [15:0]     wb_dat_i,
    output logic [15:0]     wb_dat_o,
    input  logic            wb_we_i,
    input  logic            wb_stb_i,
    input  logic            wb_cyc_i,
    input  logic [1:0]      wb_sel_i,
    output logic            wb_ack_o,
    output logic [NCH-1:0]  pit_o,
    output logic [NCH-1:0]  cnt_flag_o,
    output logic            pit_irq_o
);
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_MOD  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;
    localparam logic [4:0] PRE_MAX  = 5'(PRE_SIZE);
    localparam logic [PRE_SIZE-1:0]   PRE_ONES = '1;
    localparam logic [COUNT_SIZE-1:0] CNT_ONE  = COUNT_SIZE'(1);
`ifdef PIT_CHAIN_EN
    localparam bit CHAIN_OK = 1'b1;
`else
    localparam bit CHAIN_OK = 1'b0;
`endif

    logic        ack_q, ack_d;
    logic [15:0] datOut_q, datOut_d, rdData;
    logic        access, wrEn;
    logic [2:0]  chSel;
    logic [1:0]  regSel;
    logic [15:0] selMask;
    logic [NCH-1:0] pitVec, flagVec, ienVec;
    logic [15:0] ctrlRd [NCH];
    logic [15:0] modRd  [NCH];
    logic [15:0] cntRd  [NCH];

    assign access  = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wrEn    = access & wb_we_i;
    assign chSel   = wb_adr_i[4:2];
    assign regSel  = wb_adr_i[1:0];
    assign selMask = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic                  en_q, en_d, ien_q, ien_d, oneShot_q, oneShot_d, chain_q, chain_d;
        logic [3:0]            pre_q, pre_d;
        logic [COUNT_SIZE-1:0] mod_q, mod_d, cnt_q, cnt_d;
        logic [PRE_SIZE-1:0]   preCnt_q, preCnt_d, preMask;
        logic                  flag_q, flag_d, pit_q, pit_d;
        logic                  hit, wrCtrl, wrMod, wrStat, chainIn, preTick, tick, rollover;
        logic [4:0]            preEff;
        logic [3:0]            lowNew, preNew;
        logic [15:0]           modNew;

`ifdef PIT_CHAIN_EN
        if (c > 0) begin : g_link
            assign chainIn = pitVec[c-1];
        end else begin : g_head
            assign chainIn = 1'b0;
        end
`else
        assign chainIn = 1'b0;
`endif

        assign hit    = wrEn && (chSel == 3'(c));
        assign wrCtrl = hit && (regSel == REG_CTRL);
        assign wrMod  = hit && (regSel == REG_MOD);
        assign wrStat = hit && (regSel == REG_STAT);
        assign lowNew = wb_sel_i[0] ? wb_dat_i[3:0] : {chain_q, oneShot_q, ien_q, en_q};
        assign preNew = wb_sel_i[1] ? wb_dat_i[11:8] : pre_q;
        assign modNew = (wb_dat_i & selMask) | (16'(mod_q) & ~selMask);

        // Prescaler terminal count is 2^PRE-1, with PRE clipped to the counter width.
        assign preEff   = ({1'b0, pre_q} > PRE_MAX) ? PRE_MAX : {1'b0, pre_q};
        assign preMask  = ~(PRE_ONES << preEff);
        assign preTick  = (preCnt_q == preMask);
        assign tick     = en_q && (chain_q ? chainIn : preTick);
        assign rollover = tick && ((mod_q == '0) ? (cnt_q == '1) : (cnt_q == mod_q));

        // Bus writes are applied last so they override counting in the same cycle,
        // while a rollover beats a concurrent flag clear.
        always_comb begin
            en_d      = en_q;
            ien_d     = ien_q;
            oneShot_d = oneShot_q;
            chain_d   = chain_q;
            pre_d     = pre_q;
            mod_d     = mod_q;
            cnt_d     = cnt_q;
            preCnt_d  = preCnt_q;
            flag_d    = flag_q;
            pit_d     = 1'b0;
            if (!en_q) begin
                cnt_d    = CNT_ONE;
                preCnt_d = '0;
            end else begin
                preCnt_d = (chain_q || preTick) ? '0 : preCnt_q + 1'b1;
                if (tick) begin
                    cnt_d = rollover ? CNT_ONE : cnt_q + 1'b1;
                end
            end
            if (wrStat && wb_sel_i[0] && wb_dat_i[0]) begin
                flag_d = 1'b0;
            end
            if (rollover) begin
                flag_d = 1'b1;
                pit_d  = 1'b1;
                if (oneShot_q) begin
                    en_d = 1'b0;
                end
            end
            if (wrCtrl) begin
                en_d      = lowNew[0];
                ien_d     = lowNew[1];
                oneShot_d = lowNew[2];
                chain_d   = (CHAIN_OK && c > 0) ? lowNew[3] : 1'b0;
                pre_d     = preNew;
                cnt_d     = CNT_ONE;
                preCnt_d  = '0;
            end
            if (wrMod) begin
                mod_d    = modNew[COUNT_SIZE-1:0];
                cnt_d    = CNT_ONE;
                preCnt_d = '0;
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                en_q      <= 1'b0;
                ien_q     <= 1'b0;
                oneShot_q <= 1'b0;
                chain_q   <= 1'b0;
                pre_q     <= '0;
                mod_q     <= '0;
                cnt_q     <= CNT_ONE;
                preCnt_q  <= '0;
                flag_q    <= 1'b0;
                pit_q     <= 1'b0;
            end else begin
                en_q      <= en_d;
                ien_q     <= ien_d;
                oneShot_q <= oneShot_d;
                chain_q   <= chain_d;
                pre_q     <= pre_d;
                mod_q     <= mod_d;
                cnt_q     <= cnt_d;
                preCnt_q  <= preCnt_d;
                flag_q    <= flag_d;
                pit_q     <= pit_d;
            end
        end

        assign pitVec[c]  = pit_q;
        assign flagVec[c] = flag_q;
        assign ienVec[c]  = ien_q;
        assign ctrlRd[c]  = {4'b0, pre_q, 4'b0, chain_q, oneShot_q, ien_q, en_q};
        assign modRd[c]   = 16'(mod_q);
        assign cntRd[c]   = 16'(cnt_q);
    end

    always_comb begin
        rdData = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chSel == 3'(i)) begin
                case (regSel)
                    REG_CTRL: rdData = ctrlRd[i];
                    REG_MOD:  rdData = modRd[i];
                    REG_CNT:  rdData = cntRd[i];
                    REG_STAT: rdData = {15'b0, flagVec[i]};
                    default:  rdData = '0;
                endcase
            end
        end
    end

    always_comb begin
        ack_d    = access;
        datOut_d = access ? rdData : datOut_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            datOut_q <= '0;
        end else begin
            ack_q    <= ack_d;
            datOut_q <= datOut_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = datOut_q;
    assign pit_o      = pitVec;
    assign cnt_flag_o = flagVec;
    assign pit_irq_o  = |(flagVec & ienVec);
endmodule

// File: tb/tb_pit_multi.sv
// Directed bench for pit_multi: register vector table plus timing sequences.
// Chain-mode sequences are compiled in when PIT_CHAIN_EN is defined.
module tb_pit_multi;
    localparam int NCH = 4;
`ifdef PIT_CHAIN_EN
    localparam logic [15:0] CHAIN_RB = 16'h0008;
`else
    localparam logic [15:0] CHAIN_RB = 16'h0000;
`endif

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i = 1'b1;
    logic [4:0]     wb_adr_i = '0;
    logic [15:0]    wb_dat_i = '0;
    logic [15:0]    wb_dat_o;
    logic           wb_we_i  = 1'b0;
    logic           wb_stb_i = 1'b0;
    logic           wb_cyc_i = 1'b0;
    logic [1:0]     wb_sel_i = '0;
    logic           wb_ack_o;
    logic [NCH-1:0] pit_o;
    logic [NCH-1:0] cnt_flag_o;
    logic           pit_irq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  adr;
        logic        doWrite;
        logic [15:0] wdata;
        logic [1:0]  sel;
        logic [15:0] expRead;
        string       name;
    } vec_t;

    vec_t vecs[16];

    pit_multi #(.NCH(NCH), .COUNT_SIZE(16), .PRE_SIZE(15)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .pit_o(pit_o), .cnt_flag_o(cnt_flag_o),
        .pit_irq_o(pit_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [4:0] adr(input int ch, input int r);
        return {3'(ch), 2'(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic busAccess(input logic [4:0] a, input logic we, input logic [15:0] d,
                             input logic [1:0] sel, output logic [15:0] rd);
        bit seen = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge wb_clk_i); #1;
            seen = wb_ack_o;
        end
        rd = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL ackTimeout: got no ack, want ack within 8 cycles");
        end
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [15:0] d, input logic [1:0] sel);
        logic [15:0] dummy;
        busAccess(a, 1'b1, d, sel, dummy);
    endtask

    task automatic busRead(input logic [4:0] a, output logic [15:0] rd);
        busAccess(a, 1'b0, 16'h0000, 2'b11, rd);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [15:0] rd;
        if (v.doWrite) busWrite(v.adr, v.wdata, v.sel);
        busRead(v.adr, rd);
        checkOutput(v.name, rd, v.expRead);
    endtask

    // Expects pulses on pit_o[ch] at cycle first, first+period, ... after the last write ack.
    task automatic watchPit(input int ch, input int cycles, input int period,
                            input int first, input string name);
        for (int k = 1; k <= cycles; k++) begin
            @(posedge wb_clk_i); #1;
            checkOutput($sformatf("%s_k%0d", name, k), 16'(pit_o[ch]),
                        16'((k >= first) && ((k - first) % period == 0)));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        seenPulse;

        vecs[0]  = '{adr(0,0), 1'b1, 16'hF0F6, 2'b11, 16'h0006, "ctrlFullWrite"};
        vecs[1]  = '{adr(0,0), 1'b1, 16'h0A06, 2'b10, 16'h0A06, "ctrlHighLane"};
        vecs[2]  = '{adr(0,0), 1'b1, 16'h0000, 2'b01, 16'h0A00, "ctrlLowLane"};
        vecs[3]  = '{adr(1,1), 1'b1, 16'h1234, 2'b11, 16'h1234, "modFull"};
        vecs[4]  = '{adr(1,1), 1'b1, 16'hAB00, 2'b10, 16'hAB34, "modHighLane"};
        vecs[5]  = '{adr(1,1), 1'b1, 16'h00CD, 2'b01, 16'hABCD, "modLowLane"};
        vecs[6]  = '{adr(2,2), 1'b1, 16'h5555, 2'b11, 16'h0001, "cntWriteIgnored"};
        vecs[7]  = '{adr(3,3), 1'b0, 16'h0000, 2'b11, 16'h0000, "statIdle"};
        vecs[8]  = '{adr(3,0), 1'b1, 16'h0008, 2'b11, CHAIN_RB, "chainBitCh3"};
        vecs[9]  = '{adr(0,0), 1'b1, 16'h0008, 2'b11, 16'h0000, "chainBitCh0"};
        vecs[10] = '{adr(7,0), 1'b1, 16'hFFFF, 2'b11, 16'h0000, "ch7Read"};
        vecs[11] = '{adr(3,0), 1'b0, 16'h0000, 2'b11, CHAIN_RB, "ch3NoAlias"};
        vecs[12] = '{adr(5,1), 1'b1, 16'h7777, 2'b11, 16'h0000, "ch5Read"};
        vecs[13] = '{adr(1,1), 1'b0, 16'h0000, 2'b11, 16'hABCD, "ch1NoAlias"};
        vecs[14] = '{adr(1,1), 1'b1, 16'h0000, 2'b11, 16'h0000, "modRestore"};
        vecs[15] = '{adr(3,0), 1'b1, 16'h0000, 2'b11, 16'h0000, "ctrlRestore"};

        repeat (3) @(posedge wb_clk_i);
        #1;
        checkOutput("rstAck", 16'(wb_ack_o), 16'h0);
        checkOutput("rstDat", wb_dat_o, 16'h0);
        checkOutput("rstPit", 16'(pit_o), 16'h0);
        checkOutput("rstFlag", 16'(cnt_flag_o), 16'h0);
        checkOutput("rstIrq", 16'(pit_irq_o), 16'h0);
        wb_rst_i = 1'b0;
        busRead(adr(0,2), rd);
        checkOutput("rstCnt", rd, 16'h0001);
        busRead(adr(0,0), rd);
        checkOutput("rstCtrl", rd, 16'h0000);

        // One wait state: ack for one cycle, low for the next while strobe stays up.
        busWrite(adr(2,1), 16'h0042, 2'b11);
        @(posedge wb_clk_i); #1;
        wb_adr_i = adr(2,1); wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        checkOutput("ackNotEarly", 16'(wb_ack_o), 16'h0);
        @(posedge wb_clk_i); #1;
        checkOutput("ackRise", 16'(wb_ack_o), 16'h1);
        checkOutput("ackData", wb_dat_o, 16'h0042);
        @(posedge wb_clk_i); #1;
        checkOutput("ackOneCycle", 16'(wb_ack_o), 16'h0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        busWrite(adr(2,1), 16'h0000, 2'b11);

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        busWrite(adr(0,1), 16'd5, 2'b11);
        busWrite(adr(0,0), 16'h0001, 2'b11);
        watchPit(0, 12, 5, 5, "pit0Mod5");
        busWrite(adr(0,0), 16'h0000, 2'b11);
        checkOutput("flag0Set", 16'(cnt_flag_o[0]), 16'h1);
        busWrite(adr(0,3), 16'h0001, 2'b01);
        checkOutput("flag0Clear", 16'(cnt_flag_o[0]), 16'h0);

        busWrite(adr(1,1), 16'd3, 2'b11);
        busWrite(adr(1,0), 16'h0203, 2'b11);
        for (int k = 1; k <= 24; k++) begin
            @(posedge wb_clk_i); #1;
            checkOutput($sformatf("pit1Pre2_k%0d", k), 16'(pit_o[1]), 16'(k % 12 == 0));
            checkOutput($sformatf("irq1_k%0d", k), 16'(pit_irq_o), 16'(k >= 12));
        end
        busWrite(adr(1,3), 16'h0001, 2'b01);
        checkOutput("irqDropped", 16'(pit_irq_o), 16'h0);
        checkOutput("flag1Clear", 16'(cnt_flag_o[1]), 16'h0);
        busWrite(adr(1,0), 16'h0000, 2'b11);

        busWrite(adr(2,1), 16'd4, 2'b11);
        busWrite(adr(2,0), 16'h0005, 2'b11);
        watchPit(2, 20, 1000, 4, "pit2OneShot");
        busRead(adr(2,0), rd);
        checkOutput("oneShotCtrl", rd, 16'h0004);
        busRead(adr(2,2), rd);
        checkOutput("oneShotCnt", rd, 16'h0001);
        checkOutput("oneShotFlag", 16'(cnt_flag_o[2]), 16'h1);
        busWrite(adr(2,3), 16'h0001, 2'b01);

        // Clear write lands on the second rollover edge of ch0.
        busWrite(adr(0,0), 16'h0001, 2'b11);
        repeat (8) @(posedge wb_clk_i);
        busWrite(adr(0,3), 16'h0001, 2'b01);
        checkOutput("clearOnRollPit", 16'(pit_o[0]), 16'h1);
        checkOutput("clearOnRollFlag", 16'(cnt_flag_o[0]), 16'h1);
        busWrite(adr(0,0), 16'h0000, 2'b11);
        busWrite(adr(0,3), 16'h0001, 2'b01);
        checkOutput("flag0Cleared", 16'(cnt_flag_o[0]), 16'h0);

        busWrite(adr(0,1), 16'd2, 2'b11);
        busWrite(adr(0,0), 16'h0003, 2'b11);
        repeat (3) @(posedge wb_clk_i);
        #1;
        checkOutput("irqBeforeRst", 16'(pit_irq_o), 16'h1);
        wb_rst_i = 1'b1;
        wb_adr_i = adr(0,1); wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge wb_clk_i); #1;
        checkOutput("midRstAck", 16'(wb_ack_o), 16'h0);
        checkOutput("midRstDat", wb_dat_o, 16'h0);
        checkOutput("midRstPit", 16'(pit_o), 16'h0);
        checkOutput("midRstFlag", 16'(cnt_flag_o), 16'h0);
        checkOutput("midRstIrq", 16'(pit_irq_o), 16'h0);
        wb_rst_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        busRead(adr(0,2), rd);
        checkOutput("midRstCnt", rd, 16'h0001);
        busRead(adr(0,0), rd);
        checkOutput("midRstCtrl", rd, 16'h0000);
        seenPulse = 1'b0;
        repeat (10) begin
            @(posedge wb_clk_i); #1;
            seenPulse = seenPulse | (|pit_o);
        end
        checkOutput("idleAfterRst", 16'(seenPulse), 16'h0);

`ifdef PIT_CHAIN_EN
        busWrite(adr(1,1), 16'd3, 2'b11);
        busWrite(adr(1,0), 16'h0009, 2'b11);
        busWrite(adr(0,1), 16'd10, 2'b11);
        busWrite(adr(0,0), 16'h0001, 2'b11);
        watchPit(1, 62, 30, 31, "pit1Chain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
